load_store_unit: RTL and testbench

//  Memory-access stage that consumes the ALU's effective address (alu_result) for the
//  `ALU_LB/LH/LW/LBU/LHU/SB/SH/SW codes from define.vh and drives the data-memory port.

---
 rtl/load_store_unit.sv | 169 ++++++++++++++++
 tb/tb_load_store_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-access stage: byte-lane steering, write strobes, load extension,
// misalignment detection and a req/ack handshake with a timeout abort.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  alucode,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    // Memory-access ALU codes (mirror of the decoder's define.vh values)
    localparam logic [5:0] ALU_LB  = 6'd18;
    localparam logic [5:0] ALU_LH  = 6'd19;
    localparam logic [5:0] ALU_LW  = 6'd20;
    localparam logic [5:0] ALU_LBU = 6'd21;
    localparam logic [5:0] ALU_LHU = 6'd22;
    localparam logic [5:0] ALU_SB  = 6'd23;
    localparam logic [5:0] ALU_SH  = 6'd24;
    localparam logic [5:0] ALU_SW  = 6'd25;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t           state, state_nxt;
    logic [5:0]       code_q;
    logic [1:0]       lo_q;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      result;

    logic             is_ld, is_st, misal, timeout;
    logic [31:0]      wdata_n, ext;
    logic [3:0]       wstrb_n;
    logic [3:0][7:0]  rbytes;
    logic [7:0]       rbyte;
    logic [15:0]      rhalf;

    assign timeout = (state == REQ) && !mem_ack && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Decode the incoming request: access class, alignment and store lane data
    always_comb begin
        is_ld   = (alucode == ALU_LB) || (alucode == ALU_LH) || (alucode == ALU_LW) ||
                  (alucode == ALU_LBU) || (alucode == ALU_LHU);
        is_st   = (alucode == ALU_SB) || (alucode == ALU_SH) || (alucode == ALU_SW);
        misal   = 1'b0;
        wdata_n = 32'h0;
        wstrb_n = 4'b0000;
        case (alucode)
            ALU_LH, ALU_LHU: misal = addr[0];
            ALU_LW:          misal = |addr[1:0];
            ALU_SB: begin
                wdata_n = {4{store_data[7:0]}};
                wstrb_n = 4'b0001 << addr[1:0];
            end
            ALU_SH: begin
                misal   = addr[0];
                wdata_n = {2{store_data[15:0]}};
                wstrb_n = addr[1] ? 4'b1100 : 4'b0011;
            end
            ALU_SW: begin
                misal   = |addr[1:0];
                wdata_n = store_data;
                wstrb_n = 4'b1111;
            end
            default: ;
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it
    always_comb begin
        rbytes = mem_rdata;
        rbyte  = rbytes[lo_q];
        rhalf  = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (code_q)
            ALU_LB:  ext = {{24{rbyte[7]}}, rbyte};
            ALU_LBU: ext = {24'h0, rbyte};
            ALU_LH:  ext = {{16{rhalf[15]}}, rhalf};
            ALU_LHU: ext = {16'h0, rhalf};
            ALU_LW:  ext = mem_rdata;
            default: ext = 32'h0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: faulting and non-memory requests skip the bus phase
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = ((is_ld || is_st) && !misal) ? REQ : RESP;
            REQ:  if (mem_ack || timeout) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch request, run the bus phase, publish result with done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            load_data <= 32'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wstrb <= 4'b0000;
            mem_wdata <= 32'h0;
            code_q    <= 6'h0;
            lo_q      <= 2'b00;
            cnt       <= '0;
            result    <= 32'h0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy      <= 1'b1;
                    code_q    <= alucode;
                    lo_q      <= addr[1:0];
                    mem_addr  <= {addr[31:2], 2'b00};
                    mem_we    <= is_st;
                    mem_wstrb <= wstrb_n;
                    mem_wdata <= wdata_n;
                    mem_req   <= (is_ld || is_st) && !misal;
                    err       <= (is_ld || is_st) && misal;
                    cnt       <= '0;
                    result    <= 32'h0;
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        result  <= ext;
                    end else if (timeout) begin
                        // aborted access leaves the previous load result visible
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        result  <= load_data;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    load_data <= result;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

    localparam logic [5:0] ALU_ADD = 6'd0;
    localparam logic [5:0] ALU_LB  = 6'd18;
    localparam logic [5:0] ALU_LH  = 6'd19;
    localparam logic [5:0] ALU_LW  = 6'd20;
    localparam logic [5:0] ALU_LBU = 6'd21;
    localparam logic [5:0] ALU_LHU = 6'd22;
    localparam logic [5:0] ALU_SB  = 6'd23;
    localparam logic [5:0] ALU_SH  = 6'd24;
    localparam logic [5:0] ALU_SW  = 6'd25;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  alucode = 6'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        busy, done, err;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;

    int checks = 0;
    int fails  = 0;

    load_store_unit #(.TIMEOUT_CYCLES(255), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alucode(alucode), .addr(addr),
        .store_data(store_data), .busy(busy), .done(done), .err(err),
        .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Issue one request and act as memory; ack_delay<0 never acks.
    // Reports request-phase fields, REQ cycle count and edges from accept to done.
    task automatic do_access(input logic [5:0] c, input logic [31:0] a, input logic [31:0] sd,
                             input logic [31:0] rd, input int ack_delay,
                             output logic got_done, output logic got_err, output logic [31:0] ld,
                             output int reqcyc, output int ncyc, output logic [31:0] maddr,
                             output logic [3:0] strb, output logic [31:0] wd, output logic we);
        @(negedge clk);
        alucode = c; addr = a; store_data = sd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        maddr = mem_addr; strb = mem_wstrb; wd = mem_wdata; we = mem_we;
        got_done = 1'b0; got_err = 1'b0; ld = 32'h0; reqcyc = 0; ncyc = 0;
        for (int i = 0; i < 400 && !got_done; i++) begin
            if (mem_req) reqcyc++;
            mem_rdata = rd;
            mem_ack = mem_req && (ack_delay >= 0) && (reqcyc > ack_delay);
            @(posedge clk); #1;
            mem_ack = 1'b0;
            ncyc++;
            if (done) begin
                got_done = 1'b1; got_err = err; ld = load_data;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, err, mem_req, mem_we} !== 5'b0) begin
            fails++; $display("FAIL reset_ctl: got %b expected 00000", {busy, done, err, mem_req, mem_we});
        end
        checks++;
        if ({load_data, mem_addr, mem_wdata, mem_wstrb} !== 100'h0) begin
            fails++; $display("FAIL reset_data: got %h expected 0", {load_data, mem_addr, mem_wdata, mem_wstrb});
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_lw;
        logic gd, ge, we; logic [31:0] ld, ma, wd; logic [3:0] st; int rc, nc;
        do_access(ALU_LW, 32'h100, 32'h0, 32'hDEADBEEF, 3, gd, ge, ld, rc, nc, ma, st, wd, we);
        checks++; if (ma !== 32'h100) begin fails++; $display("FAIL lw_addr: got %h expected 00000100", ma); end
        checks++; if ({we, st} !== 5'b0) begin fails++; $display("FAIL lw_we_strb: got %b expected 00000", {we, st}); end
        checks++; if (rc !== 4) begin fails++; $display("FAIL lw_reqcyc: got %0d expected 4", rc); end
        checks++; if (nc !== 5) begin fails++; $display("FAIL lw_latency: got %0d expected 5", nc); end
        checks++; if ({gd, ge} !== 2'b10) begin fails++; $display("FAIL lw_done_err: got %b expected 10", {gd, ge}); end
        checks++; if (ld !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_data: got %h expected deadbeef", ld); end
        @(posedge clk); #1;
        checks++; if ({done, busy} !== 2'b00) begin fails++; $display("FAIL lw_done_once: got %b expected 00", {done, busy}); end
        // minimum latency: immediate ack
        do_access(ALU_LW, 32'h104, 32'h0, 32'h01020304, 0, gd, ge, ld, rc, nc, ma, st, wd, we);
        checks++; if ({rc[3:0], nc[3:0]} !== 8'h12) begin fails++; $display("FAIL lw_minlat: got req=%0d lat=%0d expected req=1 lat=2", rc, nc); end
        checks++; if (ld !== 32'h01020304) begin fails++; $display("FAIL lw_minlat_data: got %h expected 01020304", ld); end
    endtask

    task automatic test_load_ext;
        logic gd, ge, we; logic [31:0] ld, ma, wd; logic [3:0] st; int rc, nc;
        logic [5:0]  codes [6] = '{ALU_LB, ALU_LBU, ALU_LHU, ALU_LH, ALU_LH, ALU_LB};
        logic [31:0] addrs [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h101};
        logic [31:0] exps  [6] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF,
                                   32'hFFFF80FF, 32'h00001234, 32'h00000012};
        for (int i = 0; i < 6; i++) begin
            do_access(codes[i], addrs[i], 32'h0, 32'h80FF1234, 1, gd, ge, ld, rc, nc, ma, st, wd, we);
            checks++;
            if ({gd, ge} !== 2'b10 || ld !== exps[i]) begin
                fails++; $display("FAIL load_ext[%0d]: got done=%b err=%b data=%h expected done=1 err=0 data=%h", i, gd, ge, ld, exps[i]);
            end
        end
    endtask

    task automatic test_store;
        logic gd, ge, we; logic [31:0] ld, ma, wd; logic [3:0] st; int rc, nc;
        do_access(ALU_SB, 32'h21, 32'h000000AB, 32'h0, 0, gd, ge, ld, rc, nc, ma, st, wd, we);
        checks++; if ({we, st} !== 5'b10010) begin fails++; $display("FAIL sb_we_strb: got %b expected 10010", {we, st}); end
        checks++; if (wd !== 32'hABABABAB || ma !== 32'h20) begin fails++; $display("FAIL sb_data_addr: got %h/%h expected abababab/00000020", wd, ma); end
        checks++; if ({gd, ge} !== 2'b10 || ld !== 32'h0) begin fails++; $display("FAIL sb_done: got %b ld=%h expected 10 ld=0", {gd, ge}, ld); end
        do_access(ALU_SH, 32'h22, 32'h00001234, 32'h0, 0, gd, ge, ld, rc, nc, ma, st, wd, we);
        checks++; if ({we, st} !== 5'b11100) begin fails++; $display("FAIL sh_we_strb: got %b expected 11100", {we, st}); end
        checks++; if (wd !== 32'h12341234) begin fails++; $display("FAIL sh_data: got %h expected 12341234", wd); end
        do_access(ALU_SW, 32'h40, 32'hCAFEF00D, 32'h0, 2, gd, ge, ld, rc, nc, ma, st, wd, we);
        checks++; if ({we, st} !== 5'b11111 || wd !== 32'hCAFEF00D) begin fails++; $display("FAIL sw: got %b %h expected 11111 cafef00d", {we, st}, wd); end
        checks++; if ({gd, ge} !== 2'b10 || rc !== 3) begin fails++; $display("FAIL sw_done: got %b req=%0d expected 10 req=3", {gd, ge}, rc); end
    endtask

    task automatic test_misaligned;
        logic gd, ge, we; logic [31:0] ld, ma, wd; logic [3:0] st; int rc, nc;
        logic [5:0]  codes [3] = '{ALU_LW, ALU_SH, ALU_LHU};
        logic [31:0] addrs [3] = '{32'h102, 32'h101, 32'h103};
        for (int i = 0; i < 3; i++) begin
            do_access(codes[i], addrs[i], 32'h5555, 32'h0, 0, gd, ge, ld, rc, nc, ma, st, wd, we);
            checks++;
            if (rc !== 0 || nc !== 1 || {gd, ge} !== 2'b11) begin
                fails++; $display("FAIL misaligned[%0d]: got req=%0d lat=%0d done/err=%b expected req=0 lat=1 done/err=11", i, rc, nc, {gd, ge});
            end
        end
        // non-memory code completes without a bus access or error
        do_access(ALU_ADD, 32'h103, 32'h0, 32'h0, 0, gd, ge, ld, rc, nc, ma, st, wd, we);
        checks++;
        if (rc !== 0 || {gd, ge} !== 2'b10 || ld !== 32'h0) begin
            fails++; $display("FAIL nonmem: got req=%0d done/err=%b ld=%h expected req=0 10 0", rc, {gd, ge}, ld);
        end
    endtask

    task automatic test_timeout;
        logic gd, ge, we; logic [31:0] ld, ma, wd; logic [3:0] st; int rc, nc;
        logic got;
        do_access(ALU_LW, 32'h300, 32'h0, 32'h13579BDF, 0, gd, ge, ld, rc, nc, ma, st, wd, we);
        @(negedge clk);
        alucode = ALU_LW; addr = 32'h200; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rc = 0; nc = 0; got = 1'b0; ge = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            if (mem_req) rc++;
            if (i == 10) begin alucode = ALU_SW; addr = 32'h44; start = 1'b1; end
            @(posedge clk); #1;
            start = 1'b0;
            nc++;
            if (i == 10) begin
                checks++;
                if (mem_addr !== 32'h200 || mem_we !== 1'b0 || mem_req !== 1'b1) begin
                    fails++; $display("FAIL busy_ignore: got addr=%h we=%b req=%b expected 00000200 0 1", mem_addr, mem_we, mem_req);
                end
            end
            if (done) begin got = 1'b1; ge = err; end
        end
        checks++; if (rc !== 255) begin fails++; $display("FAIL to_reqcyc: got %0d expected 255", rc); end
        checks++; if (nc !== 256 || {got, ge} !== 2'b11) begin fails++; $display("FAIL to_done: got lat=%0d done/err=%b expected 256 11", nc, {got, ge}); end
        checks++; if (load_data !== 32'h13579BDF) begin fails++; $display("FAIL to_data: got %h expected 13579bdf", load_data); end
        @(posedge clk); #1;
        checks++; if ({done, busy, mem_req} !== 3'b000) begin fails++; $display("FAIL to_after: got %b expected 000", {done, busy, mem_req}); end
    endtask

    task automatic test_reset_mid;
        logic gd, ge, we; logic [31:0] ld, ma, wd; logic [3:0] st; int rc, nc;
        logic seen;
        @(negedge clk);
        alucode = ALU_LW; addr = 32'h500; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        checks++; if ({busy, mem_req} !== 2'b11) begin fails++; $display("FAIL rm_inreq: got %b expected 11", {busy, mem_req}); end
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if ({busy, mem_req, done} !== 3'b000) begin fails++; $display("FAIL rm_reset: got %b expected 000", {busy, mem_req, done}); end
        @(negedge clk); rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk); mem_ack = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done || mem_req || busy) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin fails++; $display("FAIL rm_no_done: got activity=%b expected 0", seen); end
        do_access(ALU_LW, 32'h104, 32'h0, 32'h0BADF00D, 1, gd, ge, ld, rc, nc, ma, st, wd, we);
        checks++; if ({gd, ge} !== 2'b10 || ld !== 32'h0BADF00D) begin fails++; $display("FAIL rm_next_lw: got %b %h expected 10 0badf00d", {gd, ge}, ld); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
